// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared definitions for the 5-stage pipeline hazard logic:
//   - hz_state_e      : hazard-controller FSM state encodings
//   - FWD_*           : operand-forwarding select codes at the EX stage
//   - REG_X0          : index of the hard-wired zero register
//   - R_DM_NONE       : EX-stage read-dm code meaning "not a load"
//   - fwd_select()    : priority compare for one EX source operand
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_LU_STALL = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  localparam logic [4:0] REG_X0    = 5'd0;
  localparam logic [2:0] R_DM_NONE = 3'd0;

  // Select the freshest producer of source register rs. x0 is never
  // forwarded; the MEM-stage result is younger than WB, so it wins.
  function automatic logic [1:0] fwd_select(
    input logic       mem_w,
    input logic [4:0] mem_rd,
    input logic       wb_w,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (wb_w && (wb_rd != REG_X0) && (wb_rd == rs)) sel = FWD_MEMWB;
    if (mem_w && (mem_rd != REG_X0) && (mem_rd == rs)) sel = FWD_EXMEM;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Pure combinational EX-stage operand-forwarding compare.
// Ports:
//   ex_rs1_i, ex_rs2_i     : EX-stage source registers
//   mem_rd_i, mem_w_reg_i  : EX/MEM destination and write enable
//   wb_rd_i,  wb_w_reg_i   : MEM/WB destination and write enable
//   fwd_a_o,  fwd_b_o      : operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
// -----------------------------------------------------------------------------
module fwd_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_w_reg_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_w_reg_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_select(mem_w_reg_i, mem_rd_i, wb_w_reg_i, wb_rd_i, ex_rs1_i);
  assign fwd_b_o = fwd_select(mem_w_reg_i, mem_rd_i, wb_w_reg_i, wb_rd_i, ex_rs2_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall / flush / forwarding controller for the 5-stage pipeline.
// One FSM sequences load-use bubbles, taken-branch redirects and data-memory
// waits; forwarding selects come from the fwd_unit sub-module.
//
// Parameters:
//   REDIRECT_CYCLES : cycles IF/ID stays flushed after a taken branch (1..15)
//   MEM_TIMEOUT     : dmem wait cycles before the sticky timeout error (1..255)
//
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   id_rs1/2, id_use_rs1/2           : ID-stage sources and use flags
//   ex_rd, ex_w_reg, ex_r_dm         : EX-stage destination, write, load code
//   ex_rs1/2, ex_branch_taken        : EX-stage sources, resolved-taken flag
//   mem_rd/mem_w_reg, wb_rd/wb_w_reg : MEM and WB destinations / writes
//   dmem_req, dmem_ready             : data-memory handshake
//   pc_en, if_id_en, id_ex_en, ex_mem_en : pipeline register load enables
//   if_id_flush, id_ex_flush         : bubble insertion
//   fwd_a, fwd_b                     : EX operand forwarding selects
//   state_o                          : current FSM state
//   mem_timeout_err                  : sticky dmem timeout, cleared by reset
//
// Optional feature (macro HAZ_PERF_CNT_EN): adds 32-bit wrapping counters
//   perf_lu_stalls, perf_redirects, perf_mem_wait_cycles.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_w_reg,
  input  logic [2:0]  ex_r_dm,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_w_reg,
  input  logic        wb_w_reg,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state_o,
  output logic        mem_timeout_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_mem_wait_cycles
`endif
);

  localparam logic [3:0] REDIR_LOAD  = 4'(REDIRECT_CYCLES - 1);
  localparam bit         REDIR_MULTI = (REDIRECT_CYCLES > 1);
  localparam logic [7:0] TIMEOUT     = 8'(MEM_TIMEOUT);

  hz_state_e  state_q, state_d;
  logic [3:0] redir_cnt_q, redir_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  logic       lu;
  logic       mw;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Load in EX whose destination is read by the instruction in ID.
  assign lu = (ex_r_dm != R_DM_NONE) && ex_w_reg && (ex_rd != REG_X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mw = dmem_req && !dmem_ready;

  fwd_unit u_fwd (
    .ex_rs1_i    (ex_rs1),
    .ex_rs2_i    (ex_rs2),
    .mem_rd_i    (mem_rd),
    .mem_w_reg_i (mem_w_reg),
    .wb_rd_i     (wb_rd),
    .wb_w_reg_i  (wb_w_reg),
    .fwd_a_o     (fwd_a_raw),
    .fwd_b_o     (fwd_b_raw)
  );

  assign fwd_a           = rst_n ? fwd_a_raw : FWD_REGFILE;
  assign fwd_b           = rst_n ? fwd_b_raw : FWD_REGFILE;
  assign state_o         = state_q;
  assign mem_timeout_err = err_q;

  always_comb begin
    // NOTE: every variable written here gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      ST_MEM_WAIT: begin
        // A branch or load-use seen on the release edge is picked up in RUN
        // on the next cycle if the EX stage still presents it.
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          if (wait_cnt_q != TIMEOUT) wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == TIMEOUT) err_d = 1'b1;
        end
      end

      default: begin
        // RUN, LU_STALL and REDIRECT share one priority chain: mw > taken > lu.
        if (mw) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          ex_mem_en   = 1'b0;
          state_d     = ST_MEM_WAIT;
          redir_cnt_d = '0;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          redir_cnt_d = REDIR_LOAD;
          state_d     = REDIR_MULTI ? ST_REDIRECT : ST_RUN;
        end else if (lu && (state_q == ST_RUN)) begin
          // Only RUN evaluates lu: LU_STALL has already bubbled the load, and
          // during REDIRECT the ID stage holds a flushed slot.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = ST_LU_STALL;
        end else if (state_q == ST_REDIRECT) begin
          if_id_flush = 1'b1;
          if (redir_cnt_q <= 4'd1) begin
            redir_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            redir_cnt_d = redir_cnt_q - 4'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase

    // Reset holds the whole pipeline frozen and bubbled.
    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= ST_RUN;
      redir_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic        lu_bubble;
  logic        redirect_acc;
  logic [31:0] perf_lu_q, perf_red_q, perf_mw_q;

  assign lu_bubble    = (state_q == ST_RUN) && !mw && !ex_branch_taken && lu;
  assign redirect_acc = (state_q != ST_MEM_WAIT) && !mw && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_q  <= '0;
      perf_red_q <= '0;
      perf_mw_q  <= '0;
    end else begin
      if (lu_bubble)                perf_lu_q  <= perf_lu_q + 32'd1;
      if (redirect_acc)             perf_red_q <= perf_red_q + 32'd1;
      if (state_q == ST_MEM_WAIT)   perf_mw_q  <= perf_mw_q + 32'd1;
    end
  end

  assign perf_lu_stalls       = perf_lu_q;
  assign perf_redirects       = perf_red_q;
  assign perf_mem_wait_cycles = perf_mw_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
- Watches the ID, EX, MEM and WB stage register fields and the data-memory handshake.
- Drives enable/flush for the PC, IF/ID, ID/EX and EX/MEM registers, plus the operand-forwarding selects at the EX stage.
- Sequences load-use bubbles, branch redirects and multi-cycle data-memory waits through one FSM.

Parameters:
- REDIRECT_CYCLES, 1, cycles IF/ID stays flushed after a taken branch (1..15)
- MEM_TIMEOUT, 255, dmem wait cycles before the sticky timeout error (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
- ex_rd  in  5  EX-stage destination register
- ex_w_reg  in  1  EX instruction writes the register file
- ex_r_dm  in  3  EX read-dm code; nonzero = load
- ex_rs1, ex_rs2  in  5 each  EX-stage source registers
- ex_branch_taken  in  1  EX-stage branch/jump resolved taken
- mem_rd, wb_rd  in  5 each  MEM/WB destination registers
- mem_w_reg, wb_w_reg  in  1 each  MEM/WB register-write enables
- dmem_req  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enables
- if_id_flush, id_ex_flush  out  1 each  insert bubble (NOP, all controls 0)
- fwd_a, fwd_b  out  2 each  00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- state_o  out  2  current FSM state
- mem_timeout_err  out  1  sticky, cleared only by reset

Behaviour:
- FSM states: RUN = 0, MEM_WAIT = 1, REDIRECT = 2, LU_STALL = 3. Reset (rst_n = 0 at clk edge) -> RUN, counters 0, err 0.
- While rst_n is low, combinational outputs are: all enables 0, both flushes 1, fwd 00.
- Condition signals:
  - lu = (ex_r_dm != 0) & ex_w_reg & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))
  - mw = dmem_req & ~dmem_ready
- Priority when conditions coincide: mw > ex_branch_taken > lu.
- RUN:
  - mw -> all enables 0, no flush; next MEM_WAIT.
  - Else taken -> if_id_flush = 1, id_ex_flush = 1, enables 1; next REDIRECT if REDIRECT_CYCLES > 1, else RUN. The redirect counter loads REDIRECT_CYCLES-1.
  - Else lu -> pc_en = 0, if_id_en = 0, id_ex_flush = 1; next LU_STALL.
  - Else all enables 1, no flush.
- LU_STALL:
  - One cycle only; outputs as RUN with the lu term masked.
  - Always returns to RUN.
  - mw and taken still apply with their RUN priority.
- MEM_WAIT:
  - All enables 0 and flushes 0 until dmem_ready = 1.
  - On ready: enables 1 and next RUN. A taken branch at that edge is handled on the following cycle, while still valid.
  - The wait counter increments each cycle and saturates at MEM_TIMEOUT; reaching it sets mem_timeout_err. The FSM keeps waiting.
  - The counter clears on exit.
- REDIRECT:
  - if_id_flush = 1, enables 1; the counter decrements and the state exits to RUN at 0.
  - A new taken branch reloads the counter.
  - mw preempts to MEM_WAIT and the remaining redirect count is discarded.
- Forwarding (combinational, every state except reset):
  - fwd_a = 10 if mem_w_reg & mem_rd != 0 & mem_rd == ex_rs1.
  - Else 01 if wb_w_reg & wb_rd != 0 & wb_rd == ex_rs1.
  - Else 00. fwd_b is the same with ex_rs2.
  - x0 is never forwarded; MEM beats WB.
- Reset asserted mid-stall or mid-wait returns to RUN on the next edge with no residual flush.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds three 32-bit wrapping output counters, all cleared by reset:
  - perf_lu_stalls: +1 per lu bubble
  - perf_redirects: +1 per taken branch accepted
  - perf_mem_wait_cycles: +1 per cycle in MEM_WAIT
- When undefined, these ports and registers are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - FSM state encodings
  - FWD_REGFILE, FWD_EXMEM, FWD_MEMWB constants
  - the x0 index constant
  - the r_dm "no load" code
- One sub-module is natural: fwd_unit (pure combinational forwarding compare), instantiated once. The FSM and counters stay in the top.

Test Plan:
- Load-use: ex_r_dm = 3'b010, ex_w_reg = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1, then state_o = 3 and back to RUN with enables 1.
- x0 / unused operand: same as above with ex_rd = 0, or id_use_rs1 = 0 -> no stall, fwd 00 for rd = 0.
- Branch with REDIRECT_CYCLES = 3: ex_branch_taken pulse -> if_id_flush high 3 cycles, id_ex_flush high the first cycle only.
- MEM wait: dmem_req = 1, dmem_ready low 4 cycles -> all enables 0 for 4 cycles, resume on ready; with MEM_TIMEOUT = 2, mem_timeout_err = 1 and stays high after exit.
- Forwarding: mem_rd = wb_rd = ex_rs1 = 7, both w_reg = 1 -> fwd_a = 10; mem_w_reg = 0 -> fwd_a = 01.
- Simultaneous events: mw, taken and lu in the same cycle -> MEM_WAIT wins. rst_n low during REDIRECT -> next cycle RUN, flushes deasserted once rst_n is high.
